ram_string_reader: RTL and testbench

RAM_STRING_READER -- requirements
Module: ram_string_reader

---
 rtl/ram_string_pkg.sv | 17 +
 rtl/ram_string_reader.sv | 147 ++++++++++++++
 tb/tb_ram_string_reader.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_string_pkg.sv
// Shared definitions for the RAM string reader.
// Holds the default RAM geometry and the traversal FSM state encoding.
package ram_string_pkg;

   localparam int unsigned DefaultAw = 10;
   localparam int unsigned DefaultDw = 10;

   typedef enum logic [2:0] {
      StIdle,
      StFetchPtr,
      StCheckSent,
      StStream,
      StWriteLen,
      StDone
   } state_e;

endpackage

// File: rtl/ram_string_reader.sv
// Walks a zero-terminated string held in RAM and streams its characters.
//
// RAM[PTR_ADDR] holds a pointer to a sentinel word that must read zero. The
// characters start right after the sentinel and end at the next zero word.
// Each nonzero character is offered on a valid/ready stream. Once the
// terminator is reached, the number of characters streamed is written to
// RAM[LEN_ADDR]. A nonzero sentinel, or a transfer from the last address,
// ends the traversal with err set and no write.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous active-high reset
//   start      request a traversal (sampled in IDLE only)
//   busy       high whenever the FSM is not idle
//   done       one-cycle pulse at the end of a traversal
//   err        error flag of the last traversal
//   length     characters streamed in the last/current traversal
//   mem_addr   RAM address
//   mem_we     RAM write enable
//   mem_wdata  RAM write data
//   mem_rdata  RAM read data (combinational read of mem_addr)
//   out_data   streamed character
//   out_valid  out_data is valid
//   out_ready  consumer accepts out_data
module ram_string_reader
   import ram_string_pkg::*;
#(
   parameter int unsigned AW       = DefaultAw,
   parameter int unsigned DW       = DefaultDw,
   parameter int unsigned PTR_ADDR = 0,
   parameter int unsigned LEN_ADDR = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] length,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] out_data,
   output logic          out_valid,
   input  logic          out_ready
);

   state_e        state;
   logic [AW-1:0] ptr;
   logic [AW-1:0] cur;
   logic          rdata_zero;
   logic          xfer;

   assign rdata_zero = (mem_rdata == '0);
   // A transfer can only happen while streaming a nonzero word.
   assign xfer       = (state == StStream) && !rdata_zero && out_ready;

   // Traversal FSM; busy and done are registered alongside the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= StIdle;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         length <= '0;
         ptr    <= '0;
         cur    <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  length <= '0;
                  err    <= 1'b0;
                  busy   <= 1'b1;
                  state  <= StFetchPtr;
               end
            end
            StFetchPtr: begin
               ptr   <= mem_rdata[AW-1:0];
               state <= StCheckSent;
            end
            StCheckSent: begin
               if (!rdata_zero) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= StDone;
               end else begin
                  cur   <= ptr + AW'(1);
                  state <= StStream;
               end
            end
            StStream: begin
               if (rdata_zero) begin
                  state <= StWriteLen;
               end else if (xfer) begin
                  length <= length + DW'(1);
                  cur    <= cur + AW'(1);
                  // Streaming past the top of the RAM would wrap to address 0.
                  if (&cur) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= StDone;
                  end
               end
            end
            StWriteLen: begin
               done  <= 1'b1;
               state <= StDone;
            end
            StDone: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
            default: begin
               busy  <= 1'b0;
               state <= StIdle;
            end
         endcase
      end
   end

   // RAM and stream drive. The RAM reads combinationally, so the stream
   // data and valid follow the current address within the same cycle.
   always_comb begin
      mem_addr  = AW'(PTR_ADDR);
      mem_we    = 1'b0;
      mem_wdata = length;
      out_data  = '0;
      out_valid = 1'b0;
      unique case (state)
         StCheckSent: mem_addr = ptr;
         StStream: begin
            mem_addr  = cur;
            out_data  = mem_rdata;
            out_valid = !rdata_zero;
         end
         StWriteLen: begin
            mem_addr = AW'(LEN_ADDR);
            mem_we   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ram_string_reader.sv
// Self-checking bench for ram_string_reader paired with a 1024x10
// async-read / sync-write RAM model.
module tb_ram_string_reader;
   import ram_string_pkg::*;

   localparam int AW = 10;
   localparam int DW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          busy;
   logic          done;
   logic          err;
   logic [DW-1:0] length;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;

   logic [DW-1:0] ram [1024];

   int vectors     = 0;
   int miscompares = 0;
   int xfers       = 0;
   int writes      = 0;

   logic [DW-1:0] exp_q [$];
   logic          stalled = 1'b0;
   logic [DW-1:0] stall_data;

   string std_str = "WafflesAndPancakes";

   always #5 clk = ~clk;

   ram_string_reader #(
      .AW(AW), .DW(DW), .PTR_ADDR(0), .LEN_ADDR(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .length    (length),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   assign mem_rdata = ram[mem_addr];

   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] = mem_wdata;
   end

   // Stream monitor: pops the scoreboard on every handshake and checks that
   // a stalled word is held until it is accepted.
   always @(negedge clk) begin
      if (mem_we) writes = writes + 1;
      if (!reset && stalled && out_valid) begin
         vectors = vectors + 1;
         if (out_data !== stall_data) begin
            miscompares = miscompares + 1;
            $display("FAIL stall_hold: got %h want %h", out_data, stall_data);
         end
      end
      if (!reset && out_valid && out_ready) begin
         vectors = vectors + 1;
         xfers   = xfers + 1;
         if (exp_q.size() == 0) begin
            miscompares = miscompares + 1;
            $display("FAIL stream_extra: got %h want no transfer", out_data);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               miscompares = miscompares + 1;
               $display("FAIL stream_data #%0d: got %h want %h", xfers, out_data, e);
            end
         end
      end
      stalled    = !reset && out_valid && !out_ready;
      stall_data = out_data;
   end

   task automatic load_standard();
      for (int i = 0; i < 1024; i++) ram[i] = '0;
      ram[0] = 10'd5;
      ram[5] = 10'd0;
      for (int i = 0; i < 18; i++) ram[6 + i] = DW'(std_str[i]);
      ram[24] = 10'd0;
   endtask

   task automatic push_standard();
      for (int i = 0; i < 18; i++) exp_q.push_back(DW'(std_str[i]));
   endtask

   task automatic clear_counts();
      xfers  = 0;
      writes = 0;
      exp_q.delete();
   endtask

   // Runs one traversal. done_cyc is the number of the cycle that carries
   // done, counting the cycle right after the start-sampling edge as 1.
   task automatic traverse(input bit toggle, input int budget, output int done_cyc);
      int k;
      done_cyc = -1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (done) done_cyc = 1;
      k = 1;
      while (k < budget && done_cyc < 0) begin
         if (toggle) out_ready = ~out_ready;
         @(posedge clk); #1;
         k = k + 1;
         if (done) done_cyc = k;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      vectors = vectors + 1;
      if ({busy, done, err, out_valid, mem_we} !== 5'b0 || length !== '0 || mem_addr !== '0) begin
         miscompares = miscompares + 1;
         $display("FAIL reset_state: got b%b d%b e%b v%b we%b len%0d addr%0d want all 0",
                  busy, done, err, out_valid, mem_we, length, mem_addr);
      end
      reset = 1'b0;
      @(posedge clk); #1;
      vectors = vectors + 1;
      if (busy !== 1'b0) begin
         miscompares = miscompares + 1;
         $display("FAIL idle_no_start: busy got %b want 0", busy);
      end
   endtask

   task automatic test_standard();
      int dc;
      load_standard();
      clear_counts();
      push_standard();
      out_ready = 1'b1;
      traverse(1'b0, 200, dc);
      vectors = vectors + 4;
      if (dc !== 23) begin
         miscompares = miscompares + 1;
         $display("FAIL std_done_cycle: got %0d want 23", dc);
      end
      if (err !== 1'b0 || length !== 10'd18) begin
         miscompares = miscompares + 1;
         $display("FAIL std_result: got err %b len %0d want err 0 len 18", err, length);
      end
      if (ram[2] !== 10'd18 || writes !== 1) begin
         miscompares = miscompares + 1;
         $display("FAIL std_write: got ram2 %0d writes %0d want 18 1", ram[2], writes);
      end
      if (xfers !== 18 || exp_q.size() !== 0) begin
         miscompares = miscompares + 1;
         $display("FAIL std_count: got %0d xfers left %0d want 18 0", xfers, exp_q.size());
      end
      @(posedge clk); #1;
      vectors = vectors + 1;
      if (done !== 1'b0 || busy !== 1'b0 || length !== 10'd18) begin
         miscompares = miscompares + 1;
         $display("FAIL std_after: got done %b busy %b len %0d want 0 0 18", done, busy, length);
      end
   endtask

   task automatic test_backpressure();
      int dc;
      load_standard();
      ram[2] = 10'h3ff;
      clear_counts();
      push_standard();
      out_ready = 1'b1;
      traverse(1'b1, 400, dc);
      out_ready = 1'b1;
      vectors = vectors + 3;
      if (dc < 0) begin
         miscompares = miscompares + 1;
         $display("FAIL bp_timeout: got no done want done");
      end
      if (length !== 10'd18 || ram[2] !== 10'd18 || err !== 1'b0) begin
         miscompares = miscompares + 1;
         $display("FAIL bp_result: got len %0d ram2 %0d err %b want 18 18 0", length, ram[2], err);
      end
      if (xfers !== 18 || exp_q.size() !== 0) begin
         miscompares = miscompares + 1;
         $display("FAIL bp_count: got %0d xfers left %0d want 18 0", xfers, exp_q.size());
      end
   endtask

   task automatic test_bad_sentinel();
      int dc;
      load_standard();
      ram[5] = 10'h41;
      ram[2] = 10'h155;
      clear_counts();
      out_ready = 1'b1;
      traverse(1'b0, 50, dc);
      vectors = vectors + 3;
      if (dc !== 3) begin
         miscompares = miscompares + 1;
         $display("FAIL bad_done_cycle: got %0d want 3", dc);
      end
      if (err !== 1'b1 || xfers !== 0) begin
         miscompares = miscompares + 1;
         $display("FAIL bad_result: got err %b xfers %0d want 1 0", err, xfers);
      end
      if (ram[2] !== 10'h155 || writes !== 0) begin
         miscompares = miscompares + 1;
         $display("FAIL bad_write: got ram2 %h writes %0d want 155 0", ram[2], writes);
      end
   endtask

   task automatic test_empty();
      int dc;
      load_standard();
      ram[6] = 10'd0;
      ram[2] = 10'h3ff;
      clear_counts();
      out_ready = 1'b1;
      traverse(1'b0, 50, dc);
      vectors = vectors + 3;
      if (dc !== 5) begin
         miscompares = miscompares + 1;
         $display("FAIL empty_done_cycle: got %0d want 5", dc);
      end
      if (err !== 1'b0 || length !== '0 || xfers !== 0) begin
         miscompares = miscompares + 1;
         $display("FAIL empty_result: got err %b len %0d xfers %0d want 0 0 0", err, length, xfers);
      end
      if (ram[2] !== 10'd0 || writes !== 1) begin
         miscompares = miscompares + 1;
         $display("FAIL empty_write: got ram2 %0d writes %0d want 0 1", ram[2], writes);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      int dc;
      load_standard();
      ram[2] = 10'h2aa;
      clear_counts();
      push_standard();
      out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      n = 0;
      while (xfers < 4 && n < 100) begin
         @(posedge clk); #1;
         n = n + 1;
      end
      out_ready = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      vectors = vectors + 2;
      if (xfers !== 4) begin
         miscompares = miscompares + 1;
         $display("FAIL mid_xfers: got %0d want 4", xfers);
      end
      if (busy !== 1'b0 || out_valid !== 1'b0 || mem_addr !== '0) begin
         miscompares = miscompares + 1;
         $display("FAIL mid_idle: got busy %b valid %b addr %0d want 0 0 0", busy, out_valid, mem_addr);
      end
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      vectors = vectors + 1;
      if (ram[2] !== 10'h2aa || writes !== 0 || busy !== 1'b0) begin
         miscompares = miscompares + 1;
         $display("FAIL mid_nowrite: got ram2 %h writes %0d busy %b want 2aa 0 0", ram[2], writes, busy);
      end
      clear_counts();
      push_standard();
      out_ready = 1'b1;
      traverse(1'b0, 200, dc);
      vectors = vectors + 1;
      if (dc !== 23 || xfers !== 18 || ram[2] !== 10'd18 || err !== 1'b0) begin
         miscompares = miscompares + 1;
         $display("FAIL mid_restart: got cyc %0d xfers %0d ram2 %0d err %b want 23 18 18 0",
                  dc, xfers, ram[2], err);
      end
   endtask

   task automatic test_wrap();
      int dc;
      for (int i = 0; i < 1024; i++) ram[i] = '0;
      ram[0]    = 10'd1020;
      ram[1020] = 10'd0;
      ram[1021] = 10'h11;
      ram[1022] = 10'h22;
      ram[1023] = 10'h33;
      ram[2]    = 10'h123;
      clear_counts();
      exp_q.push_back(10'h11);
      exp_q.push_back(10'h22);
      exp_q.push_back(10'h33);
      out_ready = 1'b1;
      traverse(1'b0, 50, dc);
      vectors = vectors + 3;
      if (dc !== 6) begin
         miscompares = miscompares + 1;
         $display("FAIL wrap_done_cycle: got %0d want 6", dc);
      end
      if (err !== 1'b1 || length !== 10'd3 || xfers !== 3 || exp_q.size() !== 0) begin
         miscompares = miscompares + 1;
         $display("FAIL wrap_result: got err %b len %0d xfers %0d want 1 3 3", err, length, xfers);
      end
      if (ram[2] !== 10'h123 || writes !== 0) begin
         miscompares = miscompares + 1;
         $display("FAIL wrap_write: got ram2 %h writes %0d want 123 0", ram[2], writes);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = '0;
      test_reset();
      test_standard();
      test_backpressure();
      test_bad_sentinel();
      test_empty();
      test_reset_mid();
      test_wrap();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
